// File: rtl/commit_unit_pkg.sv
// Shared definitions for the ROB commit unit: op codes, FSM states, store sizes
// and small op-classification helpers.
package commit_unit_pkg;

  localparam int CU_OP_W = 5;
  typedef logic [CU_OP_W-1:0] op_t;

  localparam op_t ALU_OP_ADD   = 5'h00;
  localparam op_t ALU_OP_SUB   = 5'h01;
  localparam op_t ALU_OP_AND   = 5'h02;
  localparam op_t ALU_OP_OR    = 5'h03;
  localparam op_t ALU_OP_XOR   = 5'h04;
  localparam op_t ALU_OP_SLL   = 5'h05;
  localparam op_t ALU_OP_SRL   = 5'h06;
  localparam op_t ALU_OP_SRA   = 5'h07;
  localparam op_t ALU_OP_SLT   = 5'h08;
  localparam op_t ALU_OP_SLTU  = 5'h09;
  localparam op_t ALU_OP_ADDI  = 5'h0a;
  localparam op_t ALU_OP_LUI   = 5'h0b;
  localparam op_t ALU_OP_AUIPC = 5'h0c;
  localparam op_t ALU_OP_LB    = 5'h0d;
  localparam op_t ALU_OP_LH    = 5'h0e;
  localparam op_t ALU_OP_LW    = 5'h0f;
  localparam op_t ALU_OP_BEQ   = 5'b10000;
  localparam op_t ALU_OP_BNE   = 5'b10001;
  localparam op_t ALU_OP_BLT   = 5'b10010;
  localparam op_t ALU_OP_BGE   = 5'b10011;
  localparam op_t ALU_OP_BLTU  = 5'b10100;
  localparam op_t ALU_OP_BGEU  = 5'b10101;
  localparam op_t ALU_OP_SB    = 5'h18;
  localparam op_t ALU_OP_SH    = 5'h19;
  localparam op_t ALU_OP_SW    = 5'h1a;
  localparam op_t ALU_OP_JAL   = 5'h1c;
  localparam op_t ALU_OP_JALR  = 5'h1d;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    CU_IDLE  = 2'd0,
    CU_STORE = 2'd1,
    CU_FLUSH = 2'd2
  } cu_state_e;

  function automatic logic is_branch(input op_t op);
    return (op >= ALU_OP_BEQ) && (op <= ALU_OP_BGEU);
  endfunction

  function automatic logic is_store(input op_t op);
    return (op == ALU_OP_SB) || (op == ALU_OP_SH) || (op == ALU_OP_SW);
  endfunction

  function automatic logic [1:0] store_size(input op_t op);
    case (op)
      ALU_OP_SB: return MEM_SIZE_BYTE;
      ALU_OP_SH: return MEM_SIZE_HALF;
      default:   return MEM_SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/commit_unit_branch_resolve.sv
// Combinational resolution of a committing branch/JALR: classifies the head,
// detects a misprediction and computes the fetch restart PC.
module branch_resolve
  import commit_unit_pkg::*;
#(
  parameter int OP_W = 5,
  parameter int XLEN = 32
) (
  input  logic [OP_W-1:0] op,
  input  logic            pred,
  input  logic            outcome,
  input  logic [XLEN-1:0] pred_target,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] pc,
  output logic            is_ctrl,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect
);

  logic is_br;
  logic is_jalr;

  assign is_br   = is_branch(op);
  assign is_jalr = (op == ALU_OP_JALR);

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    is_ctrl    = 1'b0;
    mispredict = 1'b0;
    redirect   = '0;
    if (is_br) begin
      is_ctrl    = 1'b1;
      mispredict = (pred != outcome) | (outcome & (pred_target != addr));
      redirect   = outcome ? addr : pc + XLEN'(4);
    end else if (is_jalr) begin
      is_ctrl    = 1'b1;
      mispredict = (pred_target != addr);
      redirect   = addr;
    end
  end

endmodule

// File: rtl/commit_unit.sv
// Retires the ROB head: register writeback, store handshake to data memory, and
// a one-cycle global flush with redirect PC on branch/JALR misprediction.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int ROB_ID_W = 3,
  parameter int OP_W     = 5,
  parameter int XLEN     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rob_commit_valid,
  input  logic [ROB_ID_W-1:0] rob_commit_id,
  input  logic [OP_W-1:0]     rob_commit_op,
  input  logic [4:0]          rob_commit_rd,
  input  logic [XLEN-1:0]     rob_commit_value,
  input  logic [XLEN-1:0]     rob_commit_pc,
  input  logic [XLEN-1:0]     rob_commit_addr,
  input  logic                rob_commit_pred,
  input  logic                rob_commit_outcome,
  input  logic [XLEN-1:0]     rob_commit_pred_target,
  output logic                rob_commit_ack,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic [ROB_ID_W-1:0] rf_wrob_id,
  output logic                mem_req,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [1:0]          mem_size,
  input  logic                mem_ready,
  output logic                flush,
  output logic [XLEN-1:0]     redirect_pc,
  output logic [31:0]         commit_count
);

  cu_state_e     state_q;
  logic          mem_req_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic [1:0]    mem_size_q;
  logic          flush_q;
  logic [XLEN-1:0] redirect_q;
  logic [31:0]   count_q;

  logic            head_ctrl;
  logic            head_misp;
  logic [XLEN-1:0] head_redirect;
  logic            head_store;
  logic            head_jalr;

  branch_resolve #(.OP_W(OP_W), .XLEN(XLEN)) u_branch_resolve (
    .op          (rob_commit_op),
    .pred        (rob_commit_pred),
    .outcome     (rob_commit_outcome),
    .pred_target (rob_commit_pred_target),
    .addr        (rob_commit_addr),
    .pc          (rob_commit_pc),
    .is_ctrl     (head_ctrl),
    .mispredict  (head_misp),
    .redirect    (head_redirect)
  );

  assign head_store = is_store(rob_commit_op);
  assign head_jalr  = (rob_commit_op == ALU_OP_JALR);

  // Ack and writeback are combinational; gating with rst keeps them silent during reset.
  always_comb begin
    rob_commit_ack = 1'b0;
    rf_we          = 1'b0;
    unique case (state_q)
      CU_IDLE: begin
        if (rob_commit_valid && !rst) begin
          if (head_store) begin
            rob_commit_ack = 1'b0;
          end else if (head_ctrl) begin
            rob_commit_ack = !head_misp;
            rf_we          = head_jalr && (rob_commit_rd != 5'd0);
          end else begin
            rob_commit_ack = 1'b1;
            rf_we          = (rob_commit_rd != 5'd0);
          end
        end
      end
      CU_STORE: rob_commit_ack = mem_ready && !rst;
      CU_FLUSH: rob_commit_ack = 1'b0;
      default:  rob_commit_ack = 1'b0;
    endcase
  end

  assign rf_waddr   = rf_we ? rob_commit_rd    : '0;
  assign rf_wdata   = rf_we ? rob_commit_value : '0;
  assign rf_wrob_id = rf_we ? rob_commit_id    : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CU_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
      count_q     <= '0;
    end else begin
      if (rob_commit_ack || (state_q == CU_FLUSH)) begin
        count_q <= count_q + 32'd1;
      end
      unique case (state_q)
        CU_IDLE: begin
          if (rob_commit_valid && head_store) begin
            mem_addr_q  <= rob_commit_addr;
            mem_wdata_q <= rob_commit_value;
            mem_size_q  <= store_size(rob_commit_op);
            mem_req_q   <= 1'b1;
            state_q     <= CU_STORE;
          end else if (rob_commit_valid && head_ctrl && head_misp) begin
            redirect_q <= head_redirect;
            flush_q    <= 1'b1;
            state_q    <= CU_FLUSH;
          end
        end
        CU_STORE: begin
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            state_q   <= CU_IDLE;
          end
        end
        CU_FLUSH: begin
          flush_q <= 1'b0;
          state_q <= CU_IDLE;
        end
        default: state_q <= CU_IDLE;
      endcase
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_size     = mem_size_q;
  assign flush        = flush_q;
  assign redirect_pc  = redirect_q;
  assign commit_count = count_q;

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: directed scenarios followed by random
// instruction streams checked against a transaction-level retirement model.
module tb_commit_unit;
  import commit_unit_pkg::*;

  localparam int ROB_ID_W = 3;
  localparam int OP_W     = 5;
  localparam int XLEN     = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                rob_commit_valid;
  logic [ROB_ID_W-1:0] rob_commit_id;
  logic [OP_W-1:0]     rob_commit_op;
  logic [4:0]          rob_commit_rd;
  logic [XLEN-1:0]     rob_commit_value;
  logic [XLEN-1:0]     rob_commit_pc;
  logic [XLEN-1:0]     rob_commit_addr;
  logic                rob_commit_pred;
  logic                rob_commit_outcome;
  logic [XLEN-1:0]     rob_commit_pred_target;
  logic                rob_commit_ack;
  logic                rf_we;
  logic [4:0]          rf_waddr;
  logic [XLEN-1:0]     rf_wdata;
  logic [ROB_ID_W-1:0] rf_wrob_id;
  logic                mem_req;
  logic [XLEN-1:0]     mem_addr;
  logic [XLEN-1:0]     mem_wdata;
  logic [1:0]          mem_size;
  logic                mem_ready;
  logic                flush;
  logic [XLEN-1:0]     redirect_pc;
  logic [31:0]         commit_count;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  logic [31:0] exp_count  = '0;
  logic [ROB_ID_W-1:0] next_id = '0;

  always #5 clk = ~clk;

  commit_unit #(.ROB_ID_W(ROB_ID_W), .OP_W(OP_W), .XLEN(XLEN)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .rob_commit_valid       (rob_commit_valid),
    .rob_commit_id          (rob_commit_id),
    .rob_commit_op          (rob_commit_op),
    .rob_commit_rd          (rob_commit_rd),
    .rob_commit_value       (rob_commit_value),
    .rob_commit_pc          (rob_commit_pc),
    .rob_commit_addr        (rob_commit_addr),
    .rob_commit_pred        (rob_commit_pred),
    .rob_commit_outcome     (rob_commit_outcome),
    .rob_commit_pred_target (rob_commit_pred_target),
    .rob_commit_ack         (rob_commit_ack),
    .rf_we                  (rf_we),
    .rf_waddr               (rf_waddr),
    .rf_wdata               (rf_wdata),
    .rf_wrob_id             (rf_wrob_id),
    .mem_req                (mem_req),
    .mem_addr               (mem_addr),
    .mem_wdata              (mem_wdata),
    .mem_size               (mem_size),
    .mem_ready              (mem_ready),
    .flush                  (flush),
    .redirect_pc            (redirect_pc),
    .commit_count           (commit_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  // One cycle with an empty ROB head: nothing may be retired or written.
  task automatic idle_cycle();
    @(negedge clk);
    rob_commit_valid = 1'b0;
    mem_ready        = 1'($urandom_range(0, 1));
    #1;
    check("idle_ack",   32'(rob_commit_ack), 32'd0);
    check("idle_rf_we", 32'(rf_we),          32'd0);
    check("idle_flush", 32'(flush),          32'd0);
    check("idle_req",   32'(mem_req),        32'd0);
    check("idle_count", commit_count,        exp_count);
  endtask

  // Presents one instruction at the head and follows it until the ROB may drop it.
  task automatic do_instr(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] value,
                          input logic [31:0] pc, input logic [31:0] addr, input logic pred,
                          input logic outcome, input logic [31:0] ptgt, input int ready_dly);
    bit st, br, jr, misp, wb, ack_exp;
    logic [31:0] redir;
    logic [31:0] sz;
    st   = (op == ALU_OP_SB) || (op == ALU_OP_SH) || (op == ALU_OP_SW);
    br   = (op >= ALU_OP_BEQ) && (op <= ALU_OP_BGEU);
    jr   = (op == ALU_OP_JALR);
    misp = br ? ((pred != outcome) || (outcome && (ptgt != addr))) : (jr ? (ptgt != addr) : 1'b0);
    redir   = jr ? addr : (outcome ? addr : pc + 32'd4);
    wb      = !st && !br && (rd != 5'd0);
    ack_exp = !st && !misp;
    sz      = (op == ALU_OP_SB) ? 32'd0 : (op == ALU_OP_SH) ? 32'd1 : 32'd2;

    @(negedge clk);
    rob_commit_valid       = 1'b1;
    rob_commit_id          = next_id;
    rob_commit_op          = op;
    rob_commit_rd          = rd;
    rob_commit_value       = value;
    rob_commit_pc          = pc;
    rob_commit_addr        = addr;
    rob_commit_pred        = pred;
    rob_commit_outcome     = outcome;
    rob_commit_pred_target = ptgt;
    mem_ready              = 1'($urandom_range(0, 1));
    #1;
    check("head_ack",   32'(rob_commit_ack), 32'(ack_exp));
    check("head_rf_we", 32'(rf_we),          32'(wb));
    if (wb) begin
      check("rf_waddr",   32'(rf_waddr),   32'(rd));
      check("rf_wdata",   rf_wdata,        value);
      check("rf_wrob_id", 32'(rf_wrob_id), 32'(next_id));
    end
    check("head_flush", 32'(flush),   32'd0);
    check("head_req",   32'(mem_req), 32'd0);
    check("head_count", commit_count, exp_count);
    if (ack_exp) exp_count++;

    if (st) begin
      for (int k = 0; k <= ready_dly; k++) begin
        @(negedge clk);
        mem_ready = (k == ready_dly);
        #1;
        check("st_req",   32'(mem_req),        32'd1);
        check("st_addr",  mem_addr,            addr);
        check("st_data",  mem_wdata,           value);
        check("st_size",  32'(mem_size),      sz);
        check("st_ack",   32'(rob_commit_ack), 32'(mem_ready));
        check("st_rf_we", 32'(rf_we),          32'd0);
        check("st_count", commit_count,        exp_count);
        if (k == ready_dly) exp_count++;
      end
    end

    if (misp) begin
      @(negedge clk);
      rob_commit_valid = 1'($urandom_range(0, 1));
      mem_ready        = 1'($urandom_range(0, 1));
      #1;
      check("fl_flush",    32'(flush),          32'd1);
      check("fl_redirect", redirect_pc,         redir);
      check("fl_ack",      32'(rob_commit_ack), 32'd0);
      check("fl_rf_we",    32'(rf_we),          32'd0);
      check("fl_req",      32'(mem_req),        32'd0);
      check("fl_count",    commit_count,        exp_count);
      exp_count++;
    end
    next_id++;
  endtask

  logic [4:0]  r_op;
  logic [31:0] r_addr;

  initial begin
    // Reset with a live head: everything must stay quiet.
    rst = 1'b1;
    rob_commit_valid = 1'b1; rob_commit_id = '0; rob_commit_op = ALU_OP_ADD;
    rob_commit_rd = 5'd5; rob_commit_value = 32'h1234; rob_commit_pc = '0;
    rob_commit_addr = '0; rob_commit_pred = 1'b0; rob_commit_outcome = 1'b0;
    rob_commit_pred_target = '0; mem_ready = 1'b0;
    #2;
    check("rst_ack",      32'(rob_commit_ack), 32'd0);
    check("rst_rf_we",    32'(rf_we),          32'd0);
    check("rst_rf_waddr", 32'(rf_waddr),       32'd0);
    check("rst_req",      32'(mem_req),        32'd0);
    check("rst_mem_addr", mem_addr,            32'd0);
    check("rst_flush",    32'(flush),          32'd0);
    check("rst_redirect", redirect_pc,         32'd0);
    check("rst_count",    commit_count,        32'd0);
    @(negedge clk);
    rst = 1'b0;
    rob_commit_valid = 1'b0;
    idle_cycle();

    // Directed scenarios.
    do_instr(ALU_OP_ADD,  5'd5, 32'h1234,     32'h0,  32'h0,    1'b0, 1'b0, 32'h0, 0);
    do_instr(ALU_OP_ADDI, 5'd0, 32'h5555,     32'h4,  32'h0,    1'b0, 1'b0, 32'h0, 0);
    do_instr(ALU_OP_SW,   5'd0, 32'hDEADBEEF, 32'h8,  32'h1000, 1'b0, 1'b0, 32'h0, 2);
    do_instr(ALU_OP_SB,   5'd0, 32'h000000AA, 32'hC,  32'h1003, 1'b0, 1'b0, 32'h0, 0);
    do_instr(ALU_OP_BEQ,  5'd0, 32'h0,        32'h40, 32'h80,   1'b0, 1'b1, 32'h0, 0);
    idle_cycle();
    do_instr(ALU_OP_BNE,  5'd0, 32'h0,        32'h40, 32'h80,   1'b1, 1'b0, 32'h80, 0);
    do_instr(ALU_OP_BLT,  5'd0, 32'h0,        32'h50, 32'h104,  1'b1, 1'b1, 32'h100, 0);
    do_instr(ALU_OP_BGE,  5'd0, 32'h0,        32'h60, 32'h200,  1'b1, 1'b1, 32'h200, 0);
    do_instr(ALU_OP_JALR, 5'd1, 32'h48,       32'h44, 32'h300,  1'b1, 1'b1, 32'h304, 0);
    do_instr(ALU_OP_JALR, 5'd2, 32'h4C,       32'h48, 32'h300,  1'b1, 1'b1, 32'h300, 0);
    do_instr(ALU_OP_JAL,  5'd1, 32'h50,       32'h4C, 32'h400,  1'b1, 1'b1, 32'h400, 0);
    do_instr(ALU_OP_BNE,  5'd0, 32'h0,        32'hFFFFFFFC, 32'h10, 1'b1, 1'b0, 32'h10, 0);
    idle_cycle();

    // Reset in the middle of a store handshake.
    @(negedge clk);
    rob_commit_valid = 1'b1; rob_commit_op = ALU_OP_SW; rob_commit_rd = 5'd0;
    rob_commit_addr = 32'h2000; rob_commit_value = 32'h0BADF00D; mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_req", 32'(mem_req), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_req",   32'(mem_req),        32'd0);
    check("mid_rst_ack",   32'(rob_commit_ack), 32'd0);
    check("mid_rst_count", commit_count,        32'd0);
    exp_count = '0;
    @(negedge clk);
    rst = 1'b0;
    rob_commit_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_instr(ALU_OP_ADD + 5'(i), 5'(i + 3), $urandom, 32'(4 * i), 32'h0, 1'b0, 1'b0, 32'h0, 0);
    end
    idle_cycle();

    // Random instruction stream.
    for (int n = 0; n < 200; n++) begin
      r_addr = $urandom;
      case ($urandom_range(0, 5))
        0, 1: r_op = 5'($urandom_range(0, 15));
        2:    r_op = ALU_OP_JAL;
        3:    r_op = ALU_OP_SB + 5'($urandom_range(0, 2));
        4:    r_op = ALU_OP_BEQ + 5'($urandom_range(0, 5));
        default: r_op = ALU_OP_JALR;
      endcase
      do_instr(r_op, 5'($urandom_range(0, 31)), $urandom, $urandom, r_addr,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 2) == 0) ? $urandom : r_addr, $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
